board_move_sequencer: RTL
=========================

BOARD_MOVE_SEQUENCER -- requirements
Module: board_move_sequencer

Interface
REQ-001 Parameter LFSR_SEED, default 16'hACE1, spawn LFSR reset value (SHALL be nonzero).
REQ-002 Parameter WIN_EXP, default 4'd11, tile exponent that wins (11 = 2048).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cmd  in  3  0 left, 1 right, 2 up, 3 down, 4 restart, 5-7 ignored.
REQ-006 cmd_valid / cmd_ready  in / out  1 each  command handshake; transfer on valid&ready.
REQ-007 board_load / board_load_data  in / in  1 / 64  test/restore preload of board.
REQ-008 row_req / row_data  out / out  1 / 16  request to shared row-merge unit; lane k = row_data[4k+3:4k], merge toward lane 0.
REQ-009 row_ack / row_result  in / in  1 / 16  one-cycle acknowledge with merged row.
REQ-010 gamingBoard  out  64  tile i = bits [4i+3:4i], i = 4*row+col; 0 empty, k means 2^k.
REQ-011 State  out  3  0 INIT, 1 PLAY, 2 WIN, 3 LOSE.
REQ-012 move_done  out  1  one-cycle pulse when a command or load completes.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, WBACK, SPAWN, CHECK.
REQ-014 cmd_ready SHALL be 1 only in IDLE; cmd 0-3 accepted only when State==PLAY, cmd 4 in any State; other cmds accepted and dropped, no pulse.
REQ-015 Move: four passes p=0..3; lane order LEFT (4p,4p+1,4p+2,4p+3), RIGHT reversed, UP (p,4+p,8+p,12+p), DOWN reversed.
REQ-016 ISSUE SHALL raise row_req with row_data gathered per REQ-015; row_req and row_data SHALL stay stable until row_ack.
REQ-017 On row_ack, row_result SHALL be latched, row_req SHALL drop next cycle, lanes scattered back in WBACK; row_ack outside WAIT SHALL be ignored.
REQ-018 After pass 3, if the board differs from its value at command accept, go SPAWN, else go IDLE, pulse move_done, no spawn.
REQ-019 Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle.
REQ-020 SPAWN SHALL latch start index s=LFSR[3:0] on entry and probe one cell per cycle, (s+n) mod 16, n=0..15; first empty cell gets 2 if LFSR[7:4]==0 else 1.
REQ-021 If no empty cell after 16 probes, SPAWN SHALL write nothing and go CHECK.
REQ-022 CHECK (one cycle): any tile >= WIN_EXP -> WIN; else no empty cell and no horizontally/vertically adjacent equal nonzero pair -> LOSE; else PLAY; then IDLE with move_done.
REQ-023 Restart SHALL clear board, State=INIT, perform two SPAWN sequences, then State=PLAY, IDLE, move_done.
REQ-024 board_load in IDLE SHALL have priority over cmd_valid (cmd_ready=0 that cycle), copy board_load_data, go CHECK; ignored outside IDLE.
REQ-025 Exponent arithmetic is the merge unit's; sequencer SHALL not modify lane values.
REQ-026 Latency: accept -> move_done = 4*(2+ack delay)+spawn probes+2 cycles; no upper bound while row_ack is absent.

Reset
REQ-027 On rst_n=0: board 0, State INIT, FSM IDLE, row_req 0, move_done 0, cmd_ready 0, LFSR=LFSR_SEED.
REQ-028 After release, the block SHALL auto-run the REQ-023 init sequence; cmd_ready 1 once State=PLAY.
REQ-029 Reset mid-move SHALL abort immediately; a later row_ack SHALL be ignored.

Verification
REQ-030 Reset release, merge model ack 1 cycle -> exactly two tiles, values in {1,2}, State=1, one move_done.
REQ-031 Load 64'h0000_0000_0000_1100 then cmd 0 -> row_data 16'h1100 pass 0; result 16'h0002 -> tile0=2 plus one spawn.
REQ-032 Load all-zero except tile0=1, cmd 0 (no change) -> move_done, no spawn, board unchanged.
REQ-033 Load board containing exponent 11 -> State=2; cmd 2 then dropped, board unchanged.
REQ-034 Load full checkerboard of 1/2 -> State=3; cmd 4 -> State INIT then PLAY, two tiles.
REQ-035 Hold row_ack low 50 cycles during WAIT, assert rst_n=0 -> row_req 0 same cycle, outputs per REQ-027.

Source files
------------

// File: rtl/board_move_sequencer.sv
// -----------------------------------------------------------------------------
// board_move_sequencer
//
// Sequences one move of a 4x4 sliding-tile game. Each move walks the board in
// four passes. Each pass gathers four cells into a row and hands the row to a
// shared external row-merge unit, which merges toward lane 0. The merged row is
// then written back to the same cells. A board that changed gets one new tile
// at a pseudo-random empty cell. After that the game state is re-evaluated.
// A restart clears the board and spawns two tiles. Reset release runs the same
// sequence automatically.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   cmd/cmd_valid/cmd_ready command handshake (0 L,1 R,2 U,3 D,4 restart)
//   board_load(_data)      preload of the whole board (test/restore)
//   row_req/row_data       request to the row-merge unit, lane k = [4k+3:4k]
//   row_ack/row_result     one-cycle acknowledge carrying the merged row
//   gamingBoard            tile i = [4i+3:4i], i = 4*row+col, value = exponent
//   State                  0 INIT, 1 PLAY, 2 WIN, 3 LOSE
//   move_done              one-cycle pulse when a command or load completes
// -----------------------------------------------------------------------------
module board_move_sequencer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [3:0]  WIN_EXP   = 4'd11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  cmd,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        board_load,
  input  logic [63:0] board_load_data,
  output logic        row_req,
  output logic [15:0] row_data,
  input  logic        row_ack,
  input  logic [15:0] row_result,
  output logic [63:0] gamingBoard,
  output logic [2:0]  State,
  output logic        move_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WBACK = 3'd3,
    SPAWN = 3'd4,
    CHECK = 3'd5
  } fsm_t;

  localparam logic [2:0] GS_INIT = 3'd0;
  localparam logic [2:0] GS_PLAY = 3'd1;
  localparam logic [2:0] GS_WIN  = 3'd2;
  localparam logic [2:0] GS_LOSE = 3'd3;

  // Cell index {row,col} visited by a given lane of a given pass.
  function automatic logic [3:0] lane_cell(input logic [1:0] dir,
                                           input logic [1:0] pass,
                                           input logic [1:0] lane);
    logic [1:0] rlane;
    rlane = 2'd3 - lane;
    case (dir)
      2'd0:    lane_cell = {pass, lane};
      2'd1:    lane_cell = {pass, rlane};
      2'd2:    lane_cell = {lane, pass};
      2'd3:    lane_cell = {rlane, pass};
      default: lane_cell = {pass, lane};
    endcase
  endfunction

  // Collect the four cells of one pass into a row, lane 0 first.
  function automatic logic [15:0] gather_row(input logic [63:0] b,
                                             input logic [1:0]  dir,
                                             input logic [1:0]  pass);
    logic [15:0] r;
    logic [3:0]  c;
    r = 16'd0;
    for (int k = 0; k < 4; k++) begin
      c = lane_cell(dir, pass, k[1:0]);
      r[4*k +: 4] = b[{c, 2'b00} +: 4];
    end
    return r;
  endfunction

  // Write a merged row back into the cells it was gathered from.
  function automatic logic [63:0] scatter_row(input logic [63:0] b,
                                              input logic [1:0]  dir,
                                              input logic [1:0]  pass,
                                              input logic [15:0] r);
    logic [63:0] nb;
    logic [3:0]  c;
    nb = b;
    for (int k = 0; k < 4; k++) begin
      c = lane_cell(dir, pass, k[1:0]);
      nb[{c, 2'b00} +: 4] = r[4*k +: 4];
    end
    return nb;
  endfunction

  // Game verdict: win tile anywhere, else lose when no empty cell and no
  // adjacent equal nonzero pair, else keep playing.
  function automatic logic [2:0] judge_board(input logic [63:0] b);
    logic       win;
    logic       room;
    logic [3:0] a;
    logic [3:0] n;
    win  = 1'b0;
    room = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a    = b[4*i +: 4];
      win  = win  | (a >= WIN_EXP);
      room = room | (a == 4'd0);
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        a    = b[4*(4*r+c) +: 4];
        n    = b[4*(4*r+c+1) +: 4];
        room = room | ((a != 4'd0) && (a == n));
      end
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        a    = b[4*(4*r+c) +: 4];
        n    = b[4*(4*r+c+4) +: 4];
        room = room | ((a != 4'd0) && (a == n));
      end
    end
    if (win) begin
      judge_board = GS_WIN;
    end else if (!room) begin
      judge_board = GS_LOSE;
    end else begin
      judge_board = GS_PLAY;
    end
  endfunction

  fsm_t        fsm_r,       fsm_s;
  logic [63:0] board_r,     board_s;
  logic [63:0] snap_r,      snap_s;
  logic [15:0] result_r,    result_s;
  logic [15:0] row_data_r,  row_data_s;
  logic        row_req_r,   row_req_s;
  logic [1:0]  dir_r,       dir_s;
  logic [1:0]  pass_r,      pass_s;
  logic [2:0]  game_r,      game_s;
  logic        move_done_r, move_done_s;
  logic [3:0]  base_r,      base_s;
  logic [3:0]  probe_r,     probe_s;
  logic        restart_r,   restart_s;
  logic        spawn_more_r, spawn_more_s;
  logic        init_pend_r, init_pend_s;
  logic [15:0] lfsr_r;
  logic        lfsr_fb_s;
  logic [3:0]  cell_s;
  logic [3:0]  spawn_val_s;
  logic        spawn_end_s;

  // Taps 16,14,13,11 in 1-based numbering.
  assign lfsr_fb_s   = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
  // Probe cell wraps modulo 16 through the 4-bit add.
  assign cell_s      = base_r + probe_r;
  assign spawn_val_s = (lfsr_r[7:4] == 4'd0) ? 4'd2 : 4'd1;

  // A load in the same cycle takes priority, so it withdraws ready.
  assign cmd_ready   = (fsm_r == IDLE) & ~init_pend_r & ~board_load;
  assign row_req     = row_req_r;
  assign row_data    = row_data_r;
  assign gamingBoard = board_r;
  assign State       = game_r;
  assign move_done   = move_done_r;

  // Free-running spawn LFSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r        <= IDLE;
      board_r      <= 64'd0;
      snap_r       <= 64'd0;
      result_r     <= 16'd0;
      row_data_r   <= 16'd0;
      row_req_r    <= 1'b0;
      dir_r        <= 2'd0;
      pass_r       <= 2'd0;
      game_r       <= GS_INIT;
      move_done_r  <= 1'b0;
      base_r       <= 4'd0;
      probe_r      <= 4'd0;
      restart_r    <= 1'b0;
      spawn_more_r <= 1'b0;
      init_pend_r  <= 1'b1;
    end else begin
      fsm_r        <= fsm_s;
      board_r      <= board_s;
      snap_r       <= snap_s;
      result_r     <= result_s;
      row_data_r   <= row_data_s;
      row_req_r    <= row_req_s;
      dir_r        <= dir_s;
      pass_r       <= pass_s;
      game_r       <= game_s;
      move_done_r  <= move_done_s;
      base_r       <= base_s;
      probe_r      <= probe_s;
      restart_r    <= restart_s;
      spawn_more_r <= spawn_more_s;
      init_pend_r  <= init_pend_s;
    end
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    fsm_s        = fsm_r;
    board_s      = board_r;
    snap_s       = snap_r;
    result_s     = result_r;
    row_data_s   = row_data_r;
    row_req_s    = row_req_r;
    dir_s        = dir_r;
    pass_s       = pass_r;
    game_s       = game_r;
    move_done_s  = 1'b0;
    base_s       = base_r;
    probe_s      = probe_r;
    restart_s    = restart_r;
    spawn_more_s = spawn_more_r;
    init_pend_s  = init_pend_r;
    spawn_end_s  = 1'b0;

    case (fsm_r)
      IDLE: begin
        if (init_pend_r || (cmd_valid && !board_load && (cmd == 3'd4))) begin
          // Restart: empty board, then two spawn sequences back to back.
          init_pend_s  = 1'b0;
          board_s      = 64'd0;
          game_s       = GS_INIT;
          restart_s    = 1'b1;
          spawn_more_s = 1'b1;
          base_s       = lfsr_r[3:0];
          probe_s      = 4'd0;
          fsm_s        = SPAWN;
        end else if (board_load) begin
          board_s = board_load_data;
          fsm_s   = CHECK;
        end else if (cmd_valid && !cmd[2] && (game_r == GS_PLAY)) begin
          snap_s     = board_r;
          dir_s      = cmd[1:0];
          pass_s     = 2'd0;
          row_data_s = gather_row(board_r, cmd[1:0], 2'd0);
          row_req_s  = 1'b1;
          fsm_s      = ISSUE;
        end else begin
          fsm_s = IDLE;
        end
      end

      ISSUE: begin
        fsm_s = WAIT;
      end

      WAIT: begin
        if (row_ack) begin
          result_s  = row_result;
          row_req_s = 1'b0;
          fsm_s     = WBACK;
        end else begin
          fsm_s = WAIT;
        end
      end

      WBACK: begin
        board_s = scatter_row(board_r, dir_r, pass_r, result_r);
        if (pass_r != 2'd3) begin
          pass_s     = pass_r + 2'd1;
          row_data_s = gather_row(board_s, dir_r, pass_r + 2'd1);
          row_req_s  = 1'b1;
          fsm_s      = ISSUE;
        end else if (board_s != snap_r) begin
          base_s  = lfsr_r[3:0];
          probe_s = 4'd0;
          fsm_s   = SPAWN;
        end else begin
          move_done_s = 1'b1;
          fsm_s       = IDLE;
        end
      end

      SPAWN: begin
        if (board_r[{cell_s, 2'b00} +: 4] == 4'd0) begin
          board_s[{cell_s, 2'b00} +: 4] = spawn_val_s;
          spawn_end_s = 1'b1;
        end else if (probe_r == 4'd15) begin
          spawn_end_s = 1'b1;
        end else begin
          probe_s = probe_r + 4'd1;
        end

        if (spawn_end_s) begin
          if (spawn_more_r) begin
            // Second restart tile: fresh start index from the LFSR.
            spawn_more_s = 1'b0;
            base_s       = lfsr_r[3:0];
            probe_s      = 4'd0;
            fsm_s        = SPAWN;
          end else if (restart_r) begin
            restart_s   = 1'b0;
            game_s      = GS_PLAY;
            move_done_s = 1'b1;
            fsm_s       = IDLE;
          end else begin
            fsm_s = CHECK;
          end
        end else begin
          fsm_s = SPAWN;
        end
      end

      CHECK: begin
        game_s      = judge_board(board_r);
        move_done_s = 1'b1;
        fsm_s       = IDLE;
      end

      default: begin
        row_req_s    = 1'b0;
        restart_s    = 1'b0;
        spawn_more_s = 1'b0;
        fsm_s        = IDLE;
      end
    endcase
  end

endmodule
